// File: rtl/ram_io_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_io_responder_if
//  Description : Byte-wide memory bus plus UART-style TX/RX streaming signals
//                shared between the memory controller side and the responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_io_responder_if #(
    parameter int ADDR_W = 32
);
    logic              rdy;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              io_full;
    logic              overflow;

    // Controller / environment side
    modport master (
        output rdy, mem_sel, mem_addr, mem_din, tx_ready, rx_data, rx_valid,
        input  mem_dout, tx_data, tx_valid, rx_ready, io_full, overflow
    );

    // Responder side
    modport slave (
        input  rdy, mem_sel, mem_addr, mem_din, tx_ready, rx_data, rx_valid,
        output mem_dout, tx_data, tx_valid, rx_ready, io_full, overflow
    );
endinterface
`default_nettype wire

// File: rtl/ram_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ram_io_responder
//  Description : Bus target holding a synchronous byte RAM below IO_BASE and a
//                UART-style port (TX/RX FIFOs, status, overflow clear) above it.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_io_responder #(
    parameter int                ADDR_W   = 32,
    parameter int                RAM_AW   = 17,
    parameter logic [ADDR_W-1:0] IO_BASE  = 32'h0003_0000,
    parameter int                TX_DEPTH = 16,
    parameter int                RX_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_io_responder_if.slave    bus
);

    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_PW + 1;
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_PW + 1;

    localparam logic [TX_CW-1:0]  c_TX_FULL   = TX_CW'(TX_DEPTH);
    localparam logic [TX_CW-1:0]  c_TX_ALMOST = TX_CW'(TX_DEPTH - 1);
    localparam logic [RX_CW-1:0]  c_RX_FULL   = RX_CW'(RX_DEPTH);
    localparam logic [ADDR_W-1:0] c_OFF_DATA  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] c_OFF_STAT  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_OFF_CLR   = ADDR_W'(8);

    // Storage
    logic [7:0] ram_q    [0:(1<<RAM_AW)-1];
    logic [7:0] tx_mem_q [0:TX_DEPTH-1];
    logic [7:0] rx_mem_q [0:RX_DEPTH-1];

    // FIFO bookkeeping
    logic [TX_PW-1:0] tx_rd_ptr_q, tx_wr_ptr_q;
    logic [TX_CW-1:0] tx_count_q,  tx_count_d;
    logic [RX_PW-1:0] rx_rd_ptr_q, rx_wr_ptr_q;
    logic [RX_CW-1:0] rx_count_q,  rx_count_d;

    // Read-data path: RAM output register kept separate from the IO result so
    // the RAM read can map onto a block RAM output register.
    logic [7:0] ram_rdata_q;
    logic [7:0] io_rdata_q, io_rdata_d;
    logic       dout_sel_ram_q, dout_sel_ram_d;
    logic       overflow_q, overflow_d;

    // Decode
    logic [ADDR_W-1:0] w_off;
    logic              w_is_ram, w_io_data, w_io_stat, w_io_clr;
    logic              w_wr, w_rd;
    logic              w_tx_full, w_tx_push, w_tx_drop, w_tx_pop, w_tx_valid;
    logic              w_rx_nonempty, w_rx_ready, w_rx_push, w_rx_pop;
    logic              w_io_full;

    assign w_off     = bus.mem_addr - IO_BASE;
    assign w_is_ram  = (bus.mem_addr < IO_BASE);
    assign w_io_data = !w_is_ram && (w_off == c_OFF_DATA);
    assign w_io_stat = !w_is_ram && (w_off == c_OFF_STAT);
    assign w_io_clr  = !w_is_ram && (w_off == c_OFF_CLR);
    assign w_wr      = bus.rdy &&  bus.mem_sel;
    assign w_rd      = bus.rdy && !bus.mem_sel;

    // A full TX FIFO refuses a push even if it drains in the same cycle.
    assign w_tx_full  = (tx_count_q == c_TX_FULL);
    assign w_tx_valid = (tx_count_q != '0);
    assign w_tx_push  = w_wr && w_io_data && !w_tx_full;
    assign w_tx_drop  = w_wr && w_io_data &&  w_tx_full;
    assign w_tx_pop   = w_tx_valid && bus.tx_ready;
    assign w_io_full  = (tx_count_q >= c_TX_ALMOST);

    assign w_rx_nonempty = (rx_count_q != '0);
    assign w_rx_ready    = (rx_count_q != c_RX_FULL);
    assign w_rx_push     = bus.rx_valid && w_rx_ready;
    assign w_rx_pop      = w_rd && w_io_data && w_rx_nonempty;

    // Outputs
    assign bus.mem_dout = dout_sel_ram_q ? ram_rdata_q : io_rdata_q;
    assign bus.tx_data  = tx_mem_q[tx_rd_ptr_q];
    assign bus.tx_valid = w_tx_valid;
    assign bus.rx_ready = w_rx_ready;
    assign bus.io_full  = w_io_full;
    assign bus.overflow = overflow_q;

    // Next occupancy of both FIFOs; simultaneous push and pop leaves it unchanged
    always_comb begin
        tx_count_d = tx_count_q;
        rx_count_d = rx_count_q;
        case ({w_tx_push, w_tx_pop})
            2'b10:   tx_count_d = tx_count_q + TX_CW'(1);
            2'b01:   tx_count_d = tx_count_q - TX_CW'(1);
            default: tx_count_d = tx_count_q;
        endcase
        case ({w_rx_push, w_rx_pop})
            2'b10:   rx_count_d = rx_count_q + RX_CW'(1);
            2'b01:   rx_count_d = rx_count_q - RX_CW'(1);
            default: rx_count_d = rx_count_q;
        endcase
    end

    // IO read result, read-path select and sticky overflow (set beats clear)
    always_comb begin
        io_rdata_d     = io_rdata_q;
        dout_sel_ram_d = dout_sel_ram_q;
        overflow_d     = overflow_q;
        if (w_rd) begin
            dout_sel_ram_d = w_is_ram;
            if (w_io_data) begin
                io_rdata_d = w_rx_nonempty ? rx_mem_q[rx_rd_ptr_q] : 8'h00;
            end else if (w_io_stat) begin
                io_rdata_d = {5'b0, overflow_q, w_rx_nonempty, w_io_full};
            end else if (!w_is_ram) begin
                io_rdata_d = 8'h00;
            end
        end
        if (w_wr && w_io_clr) begin
            overflow_d = 1'b0;
        end
        if (w_tx_drop) begin
            overflow_d = 1'b1;
        end
    end

    // Byte RAM: contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr && w_is_ram) begin
            ram_q[bus.mem_addr[RAM_AW-1:0]] <= bus.mem_din;
        end
        if (w_rd && w_is_ram) begin
            ram_rdata_q <= ram_q[bus.mem_addr[RAM_AW-1:0]];
        end
    end

    // FIFO storage writes (no reset needed on data)
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= bus.mem_din;
        end
        if (w_rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= bus.rx_data;
        end
    end

    // Control state: pointers, counts, read-data registers, overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_rd_ptr_q    <= '0;
            tx_wr_ptr_q    <= '0;
            tx_count_q     <= '0;
            rx_rd_ptr_q    <= '0;
            rx_wr_ptr_q    <= '0;
            rx_count_q     <= '0;
            io_rdata_q     <= 8'h00;
            dout_sel_ram_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            if (w_tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + TX_PW'(1);
            if (w_tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + TX_PW'(1);
            if (w_rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + RX_PW'(1);
            if (w_rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + RX_PW'(1);
            tx_count_q     <= tx_count_d;
            rx_count_q     <= rx_count_d;
            io_rdata_q     <= io_rdata_d;
            dout_sel_ram_q <= dout_sel_ram_d;
            overflow_q     <= overflow_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_io_responder
//  Description : Scoreboard testbench for ram_io_responder with a queue-based
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_io_responder;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;
    localparam int          TXD     = 16;
    localparam int          RXD     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_io_responder_if #(.ADDR_W(32)) bus ();

    ram_io_responder #(
        .ADDR_W   (32),
        .RAM_AW   (17),
        .IO_BASE  (IO_BASE),
        .TX_DEPTH (TXD),
        .RX_DEPTH (RXD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] ram_m [int];
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         ovf_m = 1'b0;

    // Scoreboard queues
    logic [7:0] tx_exp[$];
    logic [7:0] rd_exp[$];

    bit         mon_en   = 1'b0;
    bit         pend_rd  = 1'b0;
    bit         pend_rst = 1'b0;
    logic [7:0] last_dout = 8'h00;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [31:0] a);
        if (a < IO_BASE)
            return ram_m.exists(int'(a[16:0])) ? ram_m[int'(a[16:0])] : 8'h00;
        else if (a == IO_BASE)
            return (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        else if (a == IO_BASE + 32'd4)
            return {5'b0, ovf_m, (rx_q.size() > 0), (tx_q.size() >= TXD - 1)};
        else
            return 8'h00;
    endfunction

    // Record which edges carried a sampled read or a reset
    always @(posedge clk) begin
        pend_rst <= rst;
        pend_rd  <= !rst && bus.rdy && !bus.mem_sel;
    end

    // Monitor: read data one cycle after a sampled read, hold otherwise; TX stream
    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (mon_en) begin
            if (pend_rst) begin
                last_dout = 8'h00;
                chk("reset_dout", bus.mem_dout, 8'h00);
            end else if (pend_rd) begin
                if (rd_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_queue: got read with no expectation at %0t", $time);
                end else begin
                    e = rd_exp.pop_front();
                    last_dout = e;
                    chk("read_data", bus.mem_dout, e);
                end
            end else begin
                chk("dout_hold", bus.mem_dout, last_dout);
            end
            if (!rst && bus.tx_valid && bus.tx_ready) begin
                if (tx_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected: got 0x%02h, expected no byte at %0t", bus.tx_data, $time);
                end else begin
                    e = tx_exp.pop_front();
                    chk("tx_data", bus.tx_data, e);
                end
            end
        end
    end

    // One bus cycle: drive, check flags against the model, update the model
    task automatic step(input bit r, input bit sel, input logic [31:0] a, input logic [7:0] d,
                        input bit txr, input bit rxv, input logic [7:0] rxd);
        int         ts, rs;
        logic [7:0] tmp;
        bus.rdy = r; bus.mem_sel = sel; bus.mem_addr = a; bus.mem_din = d;
        bus.tx_ready = txr; bus.rx_valid = rxv; bus.rx_data = rxd;
        @(negedge clk); #1;
        ts = tx_q.size();
        rs = rx_q.size();
        chk("flags", {4'b0, bus.tx_valid, bus.rx_ready, bus.io_full, bus.overflow},
                     {4'b0, (ts > 0), (rs < RXD), (ts >= TXD - 1), ovf_m});
        if (r && !sel) rd_exp.push_back(model_read(a));
        if (ts > 0 && txr) tmp = tx_q.pop_front();
        if (r && sel) begin
            if (a < IO_BASE) ram_m[int'(a[16:0])] = d;
            else if (a == IO_BASE) begin
                if (ts < TXD) begin
                    tx_q.push_back(d);
                    tx_exp.push_back(d);
                end else begin
                    ovf_m = 1'b1;
                end
            end else if (a == IO_BASE + 32'd8) ovf_m = 1'b0;
        end
        if (r && !sel && a == IO_BASE && rs > 0) tmp = rx_q.pop_front();
        if (rxv && rs < RXD) rx_q.push_back(rxd);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input bit txr);
        repeat (n) step(1'b0, 1'b0, 32'h0, 8'h00, txr, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rdy = 1'b0; bus.mem_sel = 1'b0; bus.mem_addr = '0; bus.mem_din = '0;
        bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        tx_q.delete(); rx_q.delete(); tx_exp.delete(); rd_exp.delete();
        ovf_m  = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        int op;
        logic [31:0] a;
        @(posedge clk); #1;
        do_reset();

        // RAM write then back-to-back reads
        step(1, 1, 32'h100, 8'h12, 0, 0, 8'h00);
        step(1, 1, 32'h101, 8'h34, 0, 0, 8'h00);
        step(1, 0, 32'h100, 8'h00, 0, 0, 8'h00);
        step(1, 0, 32'h101, 8'h00, 0, 0, 8'h00);
        idle(2, 0);

        // TX ordering
        for (int i = 0; i < 3; i++) step(1, 1, IO_BASE, 8'h41 + 8'(i), 0, 0, 8'h00);
        idle(1, 0);
        idle(3, 1);
        idle(1, 0);

        // TX almost-full, full, overflow, status, clear
        for (int i = 0; i < 17; i++) step(1, 1, IO_BASE, 8'(8'h80 + i), 0, 0, 8'h00);
        step(1, 0, IO_BASE + 32'd4, 8'h00, 0, 0, 8'h00);
        step(1, 1, IO_BASE + 32'd8, 8'h00, 0, 0, 8'h00);
        step(1, 0, IO_BASE + 32'd4, 8'h00, 0, 0, 8'h00);
        idle(18, 1);

        // RX pops including empty read and status
        step(0, 0, 32'h0, 8'h00, 0, 1, 8'h61);
        step(0, 0, 32'h0, 8'h00, 0, 1, 8'h62);
        for (int i = 0; i < 3; i++) step(1, 0, IO_BASE, 8'h00, 0, 0, 8'h00);
        step(1, 0, IO_BASE + 32'd4, 8'h00, 0, 0, 8'h00);

        // rdy=0 freezes the bus-side pop and holds mem_dout
        step(0, 0, 32'h0, 8'h00, 0, 1, 8'h71);
        step(0, 0, 32'h0, 8'h00, 0, 1, 8'h72);
        for (int i = 0; i < 4; i++) step(0, 0, IO_BASE, 8'h00, 0, 0, 8'h00);
        step(1, 0, IO_BASE, 8'h00, 0, 0, 8'h00);
        step(1, 0, IO_BASE, 8'h00, 0, 0, 8'h00);

        // RX fill, pop with rx_valid held high, refill
        for (int i = 0; i < RXD; i++) step(0, 0, 32'h0, 8'h00, 0, 1, 8'(8'hC0 + i));
        step(1, 0, IO_BASE, 8'h00, 0, 1, 8'hA0);
        step(0, 0, 32'h0, 8'h00, 0, 1, 8'hA1);
        step(0, 0, 32'h0, 8'h00, 0, 1, 8'hA2);
        for (int i = 0; i < RXD + 1; i++) step(1, 0, IO_BASE, 8'h00, 0, 0, 8'h00);

        // Reset with TX/RX occupied and overflow set: RAM survives
        for (int i = 0; i < 18; i++) step(1, 1, IO_BASE, 8'(i), 0, 1, 8'(i));
        do_reset();
        step(1, 0, 32'h100, 8'h00, 0, 0, 8'h00);
        step(1, 0, IO_BASE + 32'd4, 8'h00, 0, 0, 8'h00);

        // Random traffic over a pre-written RAM window and the IO window
        for (int i = 0; i < 64; i++) step(1, 1, 32'h200 + 32'(i), 8'($urandom), 0, 0, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0:       a = 32'h200 + 32'($urandom_range(0, 63));
                1, 2:    a = 32'h200 + 32'($urandom_range(0, 63));
                3, 4:    a = IO_BASE;
                5, 6:    a = IO_BASE;
                7:       a = IO_BASE + 32'd4;
                8:       a = IO_BASE + 32'd8;
                default: a = IO_BASE + 32'($urandom_range(1, 3)) * 32'd5;
            endcase
            step(($urandom_range(0, 9) != 0),
                 (op == 0 || op == 3 || op == 4 || op == 8 || (op == 9 && $urandom_range(0, 1) == 1)),
                 a, 8'($urandom),
                 (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0), 8'($urandom));
        end

        // Drain both FIFOs and confirm nothing is left outstanding
        idle(TXD + 2, 1);
        for (int i = 0; i < RXD + 1; i++) step(1, 0, IO_BASE, 8'h00, 0, 0, 8'h00);
        idle(2, 0);
        chk("tx_drain", 8'(tx_exp.size()), 8'h00);
        chk("rd_drain", 8'(rd_exp.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
